// File: rtl/voice_sampler_if.sv
// Bundle of the sample stream, capture control and delay-RAM write port for voice_sampler.
interface voice_sampler_if #(
    parameter int IN_WIDTH = 12,
    parameter int D_WIDTH  = 8,
    parameter int A_WIDTH  = 9
);
    logic                en;
    logic                adc_valid;
    logic [IN_WIDTH-1:0] adc_data;
    logic                arm;
    logic [D_WIDTH-1:0]  threshold;
    logic [D_WIDTH-1:0]  voice;
    logic                wr_en;
    logic [A_WIDTH-1:0]  wr_addr;
    logic                busy;
    logic                done;

    modport master (
        output en, adc_valid, adc_data, arm, threshold,
        input  voice, wr_en, wr_addr, busy, done
    );

    modport slave (
        input  en, adc_valid, adc_data, arm, threshold,
        output voice, wr_en, wr_addr, busy, done
    );
endinterface

// File: rtl/voice_sampler.sv
// Block-averaging decimator plus armed/triggered capture sequencer feeding the delay RAM.
// Optional macro VOICE_SAMPLER_TRIGGER_EN: ARMED waits for dec >= threshold before capturing.
module voice_sampler #(
    parameter int IN_WIDTH   = 12,
    parameter int D_WIDTH    = 8,
    parameter int A_WIDTH    = 9,
    parameter int DECIM_LOG2 = 2
) (
    input logic            clk,
    input logic            rst,
    voice_sampler_if.slave bus
);
    localparam int ACC_WIDTH = IN_WIDTH + DECIM_LOG2;
    localparam int CNT_WIDTH = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    // Averaging shift and MSB selection collapse into one shift of the running sum.
    localparam int DEC_SHIFT = DECIM_LOG2 + IN_WIDTH - D_WIDTH;
    localparam logic [CNT_WIDTH-1:0] GROUP_LAST = CNT_WIDTH'((1 << DECIM_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] grp_cnt;
    logic [ACC_WIDTH-1:0] sum;
    logic [D_WIDTH-1:0]   dec;
    logic                 accept;
    logic                 group_done;
    logic                 trigger_hit;
    logic                 do_write;
    logic                 clear_addr;
    logic                 arm_seen;

    logic [A_WIDTH-1:0]   addr;
    logic [D_WIDTH-1:0]   voice_q;
    logic                 wr_en_q;
    logic [A_WIDTH-1:0]   wr_addr_q;

    assign accept     = bus.en && bus.adc_valid;
    assign sum        = acc + ACC_WIDTH'(bus.adc_data);
    assign dec        = D_WIDTH'(sum >> DEC_SHIFT);
    assign group_done = accept && (grp_cnt == GROUP_LAST);
    assign arm_seen   = bus.en && bus.arm;

`ifdef VOICE_SAMPLER_TRIGGER_EN
    assign trigger_hit = (dec >= bus.threshold);
`else
    logic unused_threshold;
    assign trigger_hit      = 1'b1;
    assign unused_threshold = ^bus.threshold;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            grp_cnt <= '0;
        end else if (accept) begin
            if (group_done) begin
                acc     <= '0;
                grp_cnt <= '0;
            end else begin
                acc     <= sum;
                grp_cnt <= grp_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arm coinciding with a group completion in IDLE/DONE only re-arms; that group is never evaluated.
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        clear_addr = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (arm_seen) begin
                    state_next = ARMED;
                    clear_addr = 1'b1;
                end
            end
            ARMED: begin
                if (group_done && trigger_hit) begin
                    do_write   = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (group_done) begin
                    do_write = 1'b1;
                    if (addr == {A_WIDTH{1'b1}}) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // wr_en is a strobe: it drops on any edge without a write, including while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            voice_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_en_q <= do_write;
            if (do_write) begin
                voice_q   <= dec;
                wr_addr_q <= addr;
                addr      <= addr + A_WIDTH'(1);
            end
            if (clear_addr) begin
                addr <= '0;
            end
        end
    end

    assign bus.voice   = voice_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.busy    = (state == ARMED) || (state == CAPTURE);
    assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_voice_sampler.sv
// Self-checking bench: a default-size instance and a 16-word instance share one stimulus stream.
module tb_voice_sampler;
    localparam int IN_W   = 12;
    localparam int D_W    = 8;
    localparam int A_A    = 9;
    localparam int A_B    = 4;
    localparam int GROUP  = 4;
    localparam int PH_IDLE    = 0;
    localparam int PH_ARMED   = 1;
    localparam int PH_CAPTURE = 2;
    localparam int PH_DONE    = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            adc_valid = 1'b0;
    logic [IN_W-1:0] adc_data = '0;
    logic            arm = 1'b0;
    logic [D_W-1:0]  threshold = '0;

    int checks = 0;
    int errors = 0;

    voice_sampler_if #(.IN_WIDTH(IN_W), .D_WIDTH(D_W), .A_WIDTH(A_A)) bus_a ();
    voice_sampler_if #(.IN_WIDTH(IN_W), .D_WIDTH(D_W), .A_WIDTH(A_B)) bus_b ();

    assign bus_a.en = en;
    assign bus_a.adc_valid = adc_valid;
    assign bus_a.adc_data = adc_data;
    assign bus_a.arm = arm;
    assign bus_a.threshold = threshold;
    assign bus_b.en = en;
    assign bus_b.adc_valid = adc_valid;
    assign bus_b.adc_data = adc_data;
    assign bus_b.arm = arm;
    assign bus_b.threshold = threshold;

    voice_sampler #(.IN_WIDTH(IN_W), .D_WIDTH(D_W), .A_WIDTH(A_A), .DECIM_LOG2(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    voice_sampler #(.IN_WIDTH(IN_W), .D_WIDTH(D_W), .A_WIDTH(A_B), .DECIM_LOG2(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Reference model: a queue holds the current group; capture phase and next address per instance.
    int grp[$];
    int phase[2];
    int nxt[2];
    bit exp_wr[2];
    int exp_voice[2];
    int exp_addr[2];
    int m_sum;
    int m_dec;
    bit m_complete;
    bit m_trig;

    function automatic bit m_busy(input int i);
        return (phase[i] == PH_ARMED) || (phase[i] == PH_CAPTURE);
    endfunction

    function automatic bit m_done(input int i);
        return phase[i] == PH_DONE;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            grp.delete();
            for (int i = 0; i < 2; i++) begin
                phase[i] = PH_IDLE;
                nxt[i] = 0;
                exp_wr[i] = 0;
                exp_voice[i] = 0;
                exp_addr[i] = 0;
            end
        end else begin
            m_complete = 0;
            if (en && adc_valid) begin
                grp.push_back(int'(adc_data));
                if (grp.size() == GROUP) begin
                    m_sum = 0;
                    foreach (grp[k]) m_sum += grp[k];
                    m_dec = ((m_sum / GROUP) >> (IN_W - D_W)) % 256;
                    m_complete = 1;
                    grp.delete();
                end
            end
`ifdef VOICE_SAMPLER_TRIGGER_EN
            m_trig = (m_dec >= int'(threshold));
`else
            m_trig = 1;
`endif
            for (int i = 0; i < 2; i++) begin
                exp_wr[i] = 0;
                if (phase[i] == PH_IDLE || phase[i] == PH_DONE) begin
                    if (en && arm) begin
                        phase[i] = PH_ARMED;
                        nxt[i] = 0;
                    end
                end else if (m_complete && (phase[i] == PH_CAPTURE || m_trig)) begin
                    exp_wr[i] = 1;
                    exp_voice[i] = m_dec;
                    exp_addr[i] = nxt[i];
                    nxt[i]++;
                    phase[i] = (nxt[i] == (1 << ((i == 0) ? A_A : A_B))) ? PH_DONE : PH_CAPTURE;
                end
            end
        end
    end

    task automatic step(input bit e, input bit v, input logic [IN_W-1:0] d, input bit a);
        en = e;
        adc_valid = v;
        adc_data = d;
        arm = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            threshold = D_W'($urandom);
            step(1'($urandom), 1'($urandom), IN_W'($urandom), 1'($urandom));
            checks++; if (bus_a.voice !== 0) begin errors++; $display("[TB] FAIL reset_voice actual=%0h required=0", bus_a.voice); end
            checks++; if (bus_a.wr_en !== 0) begin errors++; $display("[TB] FAIL reset_wr_en actual=%0b required=0", bus_a.wr_en); end
            checks++; if (bus_a.wr_addr !== 0) begin errors++; $display("[TB] FAIL reset_wr_addr actual=%0h required=0", bus_a.wr_addr); end
            checks++; if (bus_a.busy !== 0 || bus_b.busy !== 0) begin errors++; $display("[TB] FAIL reset_busy actual=%0b/%0b required=0", bus_a.busy, bus_b.busy); end
            checks++; if (bus_a.done !== 0 || bus_b.done !== 0) begin errors++; $display("[TB] FAIL reset_done actual=%0b/%0b required=0", bus_a.done, bus_b.done); end
        end
        rst = 1'b0;
        step(1'b1, 1'b0, '0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus_a.busy !== 1) begin errors++; $display("[TB] FAIL arm_busy actual=%0b required=1", bus_a.busy); end
            checks++; if (bus_a.wr_en !== 0) begin errors++; $display("[TB] FAIL arm_no_write actual=%0b required=0", bus_a.wr_en); end
            step(1'b1, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_decimation();
        logic [IN_W-1:0] samples [4];
        samples = '{12'h100, 12'h200, 12'h300, 12'h400};
        threshold = 8'h00;
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 1'b1, samples[s], 1'b0);
            if (s < 3) begin
                checks++; if (bus_a.wr_en !== 0) begin errors++; $display("[TB] FAIL dec_early_write actual=%0b required=0", bus_a.wr_en); end
            end
        end
        checks++; if (bus_a.wr_en !== 1) begin errors++; $display("[TB] FAIL dec_wr_en actual=%0b required=1", bus_a.wr_en); end
        checks++; if (bus_a.voice !== 8'h28) begin errors++; $display("[TB] FAIL dec_voice actual=%0h required=28", bus_a.voice); end
        checks++; if (bus_a.wr_addr !== 0) begin errors++; $display("[TB] FAIL dec_wr_addr actual=%0h required=0", bus_a.wr_addr); end
        step(1'b1, 1'b0, '0, 1'b0);
        checks++; if (bus_a.wr_en !== 0) begin errors++; $display("[TB] FAIL dec_pulse actual=%0b required=0", bus_a.wr_en); end
    endtask

    task automatic test_trigger();
        do_reset();
        threshold = 8'h80;
        step(1'b1, 1'b0, '0, 1'b1);
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 1'b1, 12'h100, 1'b0);
            checks++; if (bus_a.wr_en !== exp_wr[0]) begin errors++; $display("[TB] FAIL trig_low_wr_en actual=%0b required=%0b", bus_a.wr_en, exp_wr[0]); end
        end
`ifdef VOICE_SAMPLER_TRIGGER_EN
        checks++; if (bus_a.wr_en !== 0) begin errors++; $display("[TB] FAIL trig_below_threshold actual=%0b required=0", bus_a.wr_en); end
`endif
        checks++; if (bus_a.busy !== 1) begin errors++; $display("[TB] FAIL trig_wait_busy actual=%0b required=1", bus_a.busy); end
        for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 12'hFFF, 1'b0);
        checks++; if (bus_a.wr_en !== 1) begin errors++; $display("[TB] FAIL trig_wr_en actual=%0b required=1", bus_a.wr_en); end
        checks++; if (bus_a.voice !== 8'hFF) begin errors++; $display("[TB] FAIL trig_voice actual=%0h required=ff", bus_a.voice); end
        checks++; if (bus_a.wr_addr !== exp_addr[0]) begin errors++; $display("[TB] FAIL trig_wr_addr actual=%0h required=%0h", bus_a.wr_addr, exp_addr[0]); end
`ifdef VOICE_SAMPLER_TRIGGER_EN
        checks++; if (bus_a.wr_addr !== 0) begin errors++; $display("[TB] FAIL trig_first_addr actual=%0h required=0", bus_a.wr_addr); end
`endif
        checks++; if (bus_a.busy !== 1 || bus_a.done !== 0) begin errors++; $display("[TB] FAIL trig_capture_state actual=busy%0b/done%0b required=busy1/done0", bus_a.busy, bus_a.done); end
    endtask

    task automatic test_full_buffer();
        do_reset();
        threshold = 8'h00;
        step(1'b1, 1'b0, '0, 1'b1);
        for (int g = 0; g < 16; g++) begin
            for (int s = 0; s < 4; s++) step(1'b1, 1'b1, IN_W'($urandom), 1'b0);
            checks++; if (bus_b.wr_en !== 1) begin errors++; $display("[TB] FAIL full_wr_en g%0d actual=%0b required=1", g, bus_b.wr_en); end
            checks++; if (bus_b.wr_addr !== g) begin errors++; $display("[TB] FAIL full_wr_addr actual=%0d required=%0d", bus_b.wr_addr, g); end
            checks++; if (bus_b.voice !== exp_voice[1]) begin errors++; $display("[TB] FAIL full_voice g%0d actual=%0h required=%0h", g, bus_b.voice, exp_voice[1]); end
            checks++; if (bus_b.done !== (g == 15) || bus_b.busy !== (g != 15)) begin
                errors++; $display("[TB] FAIL full_status g%0d actual=done%0b/busy%0b required=done%0b/busy%0b", g, bus_b.done, bus_b.busy, g == 15, g != 15);
            end
        end
        for (int s = 0; s < 8; s++) begin
            step(1'b1, 1'b1, IN_W'($urandom), 1'b0);
            checks++; if (bus_b.wr_en !== 0 || bus_b.done !== 1) begin errors++; $display("[TB] FAIL full_hold actual=wr%0b/done%0b required=wr0/done1", bus_b.wr_en, bus_b.done); end
        end
        step(1'b1, 1'b0, '0, 1'b1);
        checks++; if (bus_b.done !== 0 || bus_b.busy !== 1) begin errors++; $display("[TB] FAIL full_rearm actual=done%0b/busy%0b required=done0/busy1", bus_b.done, bus_b.busy); end
        for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 12'h500, 1'b0);
        checks++; if (bus_b.wr_en !== 1 || bus_b.wr_addr !== 0) begin errors++; $display("[TB] FAIL full_restart actual=wr%0b/addr%0d required=wr1/addr0", bus_b.wr_en, bus_b.wr_addr); end
    endtask

    task automatic test_enable_gating();
        int writes;
        int last_voice;
        writes = 0;
        last_voice = -1;
        do_reset();
        threshold = 8'h00;
        step(1'b1, 1'b0, '0, 1'b1);
        for (int s = 0; s < 9; s++) begin
            if (s < 2 || (s >= 5 && s < 7)) step(1'b1, 1'b1, 12'h400, 1'b0);
            else if (s < 5) step(1'b0, 1'b1, 12'hFFF, 1'b0);
            else step(1'b1, 1'b0, '0, 1'b0);
            if (bus_a.wr_en === 1'b1) begin
                writes++;
                last_voice = int'(bus_a.voice);
            end
            if (s < 6) begin
                checks++; if (bus_a.wr_en !== 0) begin errors++; $display("[TB] FAIL en_early_write s%0d actual=%0b required=0", s, bus_a.wr_en); end
            end
        end
        checks++; if (writes !== 1) begin errors++; $display("[TB] FAIL en_write_count actual=%0d required=1", writes); end
        checks++; if (last_voice !== 32'h40) begin errors++; $display("[TB] FAIL en_voice actual=%0h required=40", last_voice); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        threshold = 8'h00;
        step(1'b1, 1'b0, '0, 1'b1);
        for (int g = 0; g < 6; g++) for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 12'h800, 1'b0);
        checks++; if (bus_a.wr_en !== 1 || bus_a.wr_addr !== 5) begin errors++; $display("[TB] FAIL mid_pre_write actual=wr%0b/addr%0d required=wr1/addr5", bus_a.wr_en, bus_a.wr_addr); end
        step(1'b1, 1'b1, 12'h123, 1'b0);
        step(1'b1, 1'b1, 12'h456, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, '0, 1'b0);
        rst = 1'b0;
        checks++; if (bus_a.voice !== 0 || bus_a.wr_en !== 0 || bus_a.wr_addr !== 0) begin
            errors++; $display("[TB] FAIL mid_outputs actual=%0h/%0b/%0h required=0/0/0", bus_a.voice, bus_a.wr_en, bus_a.wr_addr);
        end
        checks++; if (bus_a.busy !== 0 || bus_a.done !== 0) begin errors++; $display("[TB] FAIL mid_idle actual=busy%0b/done%0b required=0/0", bus_a.busy, bus_a.done); end
        threshold = 8'h80;
        step(1'b1, 1'b0, '0, 1'b1);
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 1'b1, 12'hFFF, 1'b0);
            if (s < 3) begin
                checks++; if (bus_a.wr_en !== 0) begin errors++; $display("[TB] FAIL mid_partial_kept s%0d actual=%0b required=0", s, bus_a.wr_en); end
            end
        end
        checks++; if (bus_a.wr_en !== 1 || bus_a.wr_addr !== 0 || bus_a.voice !== 8'hFF) begin
            errors++; $display("[TB] FAIL mid_rearm_write actual=wr%0b/addr%0d/voice%0h required=wr1/addr0/voiceff", bus_a.wr_en, bus_a.wr_addr, bus_a.voice);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 49) == 0) threshold = D_W'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, IN_W'($urandom), $urandom_range(0, 29) == 0);
            rst = 1'b0;
            checks++; if (bus_a.wr_en !== exp_wr[0]) begin errors++; $display("[TB] FAIL rnd_a_wr_en c%0d actual=%0b required=%0b", c, bus_a.wr_en, exp_wr[0]); end
            checks++; if (bus_b.wr_en !== exp_wr[1]) begin errors++; $display("[TB] FAIL rnd_b_wr_en c%0d actual=%0b required=%0b", c, bus_b.wr_en, exp_wr[1]); end
            checks++; if (bus_a.busy !== m_busy(0) || bus_a.done !== m_done(0)) begin
                errors++; $display("[TB] FAIL rnd_a_status c%0d actual=%0b%0b required=%0b%0b", c, bus_a.busy, bus_a.done, m_busy(0), m_done(0));
            end
            checks++; if (bus_b.busy !== m_busy(1) || bus_b.done !== m_done(1)) begin
                errors++; $display("[TB] FAIL rnd_b_status c%0d actual=%0b%0b required=%0b%0b", c, bus_b.busy, bus_b.done, m_busy(1), m_done(1));
            end
            if (exp_wr[0]) begin
                checks++; if (bus_a.voice !== exp_voice[0] || bus_a.wr_addr !== exp_addr[0]) begin
                    errors++; $display("[TB] FAIL rnd_a_data c%0d actual=%0h@%0d required=%0h@%0d", c, bus_a.voice, bus_a.wr_addr, exp_voice[0], exp_addr[0]);
                end
            end
            if (exp_wr[1]) begin
                checks++; if (bus_b.voice !== exp_voice[1] || bus_b.wr_addr !== exp_addr[1]) begin
                    errors++; $display("[TB] FAIL rnd_b_data c%0d actual=%0h@%0d required=%0h@%0d", c, bus_b.voice, bus_b.wr_addr, exp_voice[1], exp_addr[1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_decimation();
        test_trigger();
        test_full_buffer();
        test_enable_gating();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule

// File: doc/voice_sampler.md
# voice_sampler

Capture front end that sits directly upstream of the signal-delay stage. It takes a raw unsigned ADC sample stream and decimates it by block averaging into D_WIDTH-bit voice samples. After arming, it waits for a level trigger, then emits one write strobe per decimated sample with an incrementing RAM address until the delay buffer (2^A_WIDTH words) is full.

## Interface
- IN_WIDTH, default 12: ADC sample width; must be ≥ D_WIDTH.
- D_WIDTH, default 8: voice sample width written to the delay RAM.
- A_WIDTH, default 9: delay RAM address width; the capture length is 2^A_WIDTH samples.
- DECIM_LOG2, default 2: decimation factor is 2^DECIM_LOG2; allowed range 0..4.

- clk  in  1  clock; all logic is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when low, all state is frozen and adc_valid is ignored.
- adc_valid  in  1  qualifies adc_data for one cycle.
- adc_data  in  IN_WIDTH  unsigned ADC sample.
- arm  in  1  single-cycle pulse that starts a capture.
- threshold  in  D_WIDTH  unsigned trigger level.
- voice  out  D_WIDTH  decimated sample; valid while wr_en is high.
- wr_en  out  1  RAM write strobe, one cycle per sample.
- wr_addr  out  A_WIDTH  write address; valid while wr_en is high.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.

## Operation
- **Decimator:** accepts a sample when `en && adc_valid`.
  - Accumulator is IN_WIDTH+DECIM_LOG2 bits wide and cannot overflow.
  - A group counter counts accepted samples from 0 to 2^DECIM_LOG2-1.
  - The accepted sample that completes a group produces avg = sum >> DECIM_LOG2 and dec = avg[IN_WIDTH-1 -: D_WIDTH], both truncated.
  - The accumulator and counter then restart from zero.
  - The decimator runs in every state.
- **FSM states:** IDLE, ARMED, CAPTURE, DONE.
  - IDLE: an arm pulse moves to ARMED.
  - ARMED: when a group completes and dec ≥ threshold, write dec at address 0 and move to CAPTURE. Otherwise stay in ARMED.
  - CAPTURE: each completed group writes dec at the next address. The write to address 2^A_WIDTH-1 moves to DONE.
  - DONE: hold. An arm pulse moves to ARMED and resets the address to 0.
  - arm is ignored in ARMED and CAPTURE.
  - If arm and a group completion occur in the same cycle in IDLE or DONE, the state moves to ARMED and that group is not evaluated for the trigger.
- **Address counter:** the next address starts at 0 on arm. Each write presents next address on wr_addr, then increments it. The counter never wraps within a capture.
- **Reset values:** voice=0, wr_en=0, wr_addr=0, busy=0, done=0, state IDLE, accumulator and group counter 0.
- **Reset mid-capture:** the partial group is discarded and no further writes occur until re-armed.

## Timing
- Write latency: voice, wr_en and wr_addr are registered and are high in the cycle immediately after the edge that accepted the group's final sample (1 cycle).
- wr_en is a 1-cycle pulse. Back-to-back writes occur only when DECIM_LOG2=0 and adc_valid is high on consecutive cycles.
- busy and done update on the same edge as the state change. done rises in the same cycle as the final wr_en.
- en low for any number of cycles loses no accepted data and does not extend the length of a group.

## Configuration
- Macro: VOICE_SAMPLER_TRIGGER_EN.
- Defined: ARMED waits for dec ≥ threshold as described above.
- Undefined: ARMED moves to CAPTURE on the first completed group regardless of its value, and the threshold input is unused.

## Test plan
Defaults unless stated; test 4 uses A_WIDTH=4.

1. **Reset:** rst high for 2 cycles with random inputs → all outputs 0; arm with no adc_valid → busy=1, wr_en stays 0.
2. **Decimation:** arm, threshold=0x00, samples 0x100, 0x200, 0x300, 0x400 → one wr_en one cycle after the 4th sample, voice=0x28, wr_addr=0.
3. **Trigger** (macro defined): threshold=0x80; a group of four 0x100 samples gives dec=0x10 → no write, busy=1. A group of four 0xFFF samples → voice=0xFF at wr_addr=0, state CAPTURE.
4. **Full buffer:** 16 groups after the trigger → wr_addr runs 0..15; done=1 and busy=0 in the same cycle as the write to address 15. Further groups → no wr_en. Then arm → done=0 and the next capture starts at address 0.
5. **Enable gating:** two accepted samples of 0x400; en=0 with three adc_valid pulses of 0xFFF; en=1 with two more samples of 0x400 → exactly one write, voice=0x40.
6. **Mid-capture reset:** rst after the write to address 5 → outputs 0, state IDLE. Re-arm plus one triggering group → write at wr_addr=0.
